// File: rtl/apb_arb_pkg.sv
// Shared types and constants for the two-requester APB master.
`timescale 1ns/1ps
package apb_arb_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_e;
  localparam int unsigned TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/apb_arch.svh
// Bus widths shared by the APB arbitrating master and its users.
`ifndef APB_ARCH_SVH
`define APB_ARCH_SVH
`define ADDR_WIDTH 32
`define DATA_WIDTH 32
`define STRB_SIZE (`DATA_WIDTH/8)
`endif

// File: rtl/apb_rr_arb.sv
// Two-way round-robin arbiter: combinational one-hot grant, last winner
// remembered on ack so the other requester wins the next tie.
`timescale 1ns/1ps
module apb_rr_arb (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_i,
  input  logic       ack_i,
  output logic [1:0] grant_o
);
  // last_q = 1 means requester 1 won last, giving requester 0 the next tie.
  logic last_q;

  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) grant_o = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      last_q <= 1'b1;
    else if (ack_i && grant_o != '0) last_q <= grant_o[1];
  end
endmodule

// File: rtl/apb_arb_master.sv
// APB master shared by two requesters; IDLE->SETUP->ACCESS with registered bus
// outputs, round-robin grant, wait-state timeout forcing an error completion.
`timescale 1ns/1ps
`include "apb_arch.svh"
module apb_arb_master
  import apb_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   wr0,
  input  logic                   wr1,
  input  logic [`ADDR_WIDTH-1:0] addr0,
  input  logic [`ADDR_WIDTH-1:0] addr1,
  input  logic [`DATA_WIDTH-1:0] wdata0,
  input  logic [`DATA_WIDTH-1:0] wdata1,
  input  logic [`STRB_SIZE-1:0]  strb0,
  input  logic [`STRB_SIZE-1:0]  strb1,
  output logic                   done0,
  output logic                   done1,
  output logic [`DATA_WIDTH-1:0] rdata0,
  output logic [`DATA_WIDTH-1:0] rdata1,
  output logic                   err0,
  output logic                   err1,
  output logic                   sel,
  output logic                   enable,
  output logic                   write,
  output logic [`ADDR_WIDTH-1:0] addr,
  output logic [`DATA_WIDTH-1:0] wdata,
  output logic [`STRB_SIZE-1:0]  strobe,
  input  logic                   ready,
  input  logic                   slverr,
  input  logic [`DATA_WIDTH-1:0] rdata
);
  state_e                 state_q, state_d;
  logic                   owner_q, owner_d;
  logic [8:0]             wait_q, wait_d, wait_inc;
  logic                   sel_q, sel_d, enable_q, enable_d, write_q, write_d;
  logic [`ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [`DATA_WIDTH-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [`STRB_SIZE-1:0]  strobe_q, strobe_d;
  logic                   done0_q, done0_d, done1_q, done1_d;
  logic                   err0_q, err0_d, err1_q, err1_d;
  logic [1:0]             eligible, grant;
  logic                   arb_ack, cpl, cpl_err;

  // A requester is blocked in the cycle its done pulse is out, so a held req
  // cannot immediately re-win the bus.
  assign eligible = {req1 & ~done1_q, req0 & ~done0_q};
  assign wait_inc = wait_q + 9'd1;

  apb_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_i   (eligible),
    .ack_i   (arb_ack),
    .grant_o (grant)
  );

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    wait_d   = wait_q;
    sel_d    = sel_q;
    enable_d = enable_q;
    write_d  = write_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strobe_d = strobe_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    arb_ack  = 1'b0;
    cpl      = 1'b0;
    cpl_err  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant != 2'b00) begin
          arb_ack = 1'b1;
          owner_d = grant[1];
          sel_d   = 1'b1;
          state_d = SETUP;
          write_d = grant[1] ? wr1 : wr0;
          addr_d  = grant[1] ? addr1 : addr0;
          // Reads leave PWDATA at its previous value and clear the strobes.
          strobe_d = '0;
          if (grant[1] && wr1) begin
            wdata_d  = wdata1;
            strobe_d = strb1;
          end else if (!grant[1] && wr0) begin
            wdata_d  = wdata0;
            strobe_d = strb0;
          end
        end
      end
      SETUP: begin
        enable_d = 1'b1;
        wait_d   = '0;
        state_d  = ACCESS;
      end
      ACCESS: begin
        if (ready) begin
          cpl     = 1'b1;
          cpl_err = slverr;
          if (!write_q && owner_q)  rdata1_d = rdata;
          if (!write_q && !owner_q) rdata0_d = rdata;
        end else begin
          wait_d = wait_inc;
          if (wait_inc == 9'(TIMEOUT)) begin
            cpl     = 1'b1;
            cpl_err = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (cpl) begin
      sel_d    = 1'b0;
      enable_d = 1'b0;
      state_d  = IDLE;
    end
    done0_d = cpl & ~owner_q;
    done1_d = cpl & owner_q;
    err0_d  = cpl & ~owner_q & cpl_err;
    err1_d  = cpl & owner_q & cpl_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      wait_q   <= '0;
      sel_q    <= 1'b0;
      enable_q <= 1'b0;
      write_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strobe_q <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      wait_q   <= wait_d;
      sel_q    <= sel_d;
      enable_q <= enable_d;
      write_q  <= write_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strobe_q <= strobe_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      err0_q   <= err0_d;
      err1_q   <= err1_d;
    end
  end

  assign sel    = sel_q;
  assign enable = enable_q;
  assign write  = write_q;
  assign addr   = addr_q;
  assign wdata  = wdata_q;
  assign strobe = strobe_q;
  assign done0  = done0_q;
  assign done1  = done1_q;
  assign err0   = err0_q;
  assign err1   = err1_q;
  assign rdata0 = rdata0_q;
  assign rdata1 = rdata1_q;
endmodule
